poly_alu_pipe: RTL and testbench
================================

Name: poly_alu_pipe

Overview:
- Parametrised, fully pipelined modular polynomial ALU. Successor to the fixed 24-bit poly ALU.
- Each accepted operation yields two results: out0 and out1.
- Supported operations: modular add, sub and mul; Cooley-Tukey (CT) and Gentleman-Sande (GS) butterflies; GS with halving.
- Sits between the poly RAM read ports and the NTT/INTT controller.
- Adds two things the fixed ALU lacks: valid/ready back-pressure and a runtime-selectable modulus width.

Parameters:
- W, 24, data and modulus width in bits.
- EXTRA_PIPE, 0, additional output register stages (0..2), for timing closure.

Ports:
- poly_clk  in  1  clock.
- poly_rst  in  1  asynchronous active-high reset.
- poly_flush  in  1  synchronous clear of all pipeline valid bits.
- poly_op  in  3  operation code, sampled with the input beat.
- poly_in_valid  in  1  input beat valid.
- poly_in_ready  out  1  ALU can accept a beat.
- poly_a  in  W  operand a, in [0,q).
- poly_b  in  W  operand b, in [0,q).
- poly_w  in  W  twiddle factor, in [0,q).
- poly_q  in  W  modulus, static during operation.
- poly_q_width  in  5  N = bit length of q, 2..W.
- poly_barret_m  in  W+1  Barrett constant, floor(2^(2N)/q).
- poly_out_valid  out  1  result beat valid.
- poly_out_ready  in  1  consumer accepts the result.
- poly_out0  out  W  result 0.
- poly_out1  out  W  result 1.
- poly_busy  out  1  any pipeline stage holds a valid beat.

Behaviour:
- Reset: all stage valid bits, poly_out_valid, poly_busy, poly_out0 and poly_out1 go to 0 asynchronously.
- Handshake:
  - A beat transfers on poly_in_valid && poly_in_ready.
  - A result transfers on poly_out_valid && poly_out_ready.
  - Global stall: stall = poly_out_valid && !poly_out_ready.
  - poly_in_ready = !stall. It is combinational and must not depend on poly_in_valid.
  - While stalled, every stage register holds, and out0/out1 stay stable.
  - Bubbles propagate and are not compressed.
- Latency: 4 + EXTRA_PIPE cycles from the accepting edge to poly_out_valid, absent stall. This latency is uniform for all ops, so results emerge in issue order.
- Pipeline stages:
  - S1 registers the operands and op, and forms the GS pre-sum s=(a+b) mod q and pre-difference d=(a-b) mod q.
  - S2 forms the product p = x*y (2W bits), where x*y = b*w for CT, d*w for GS/GSH, and a*b for MUL.
  - S3 computes t1=p>>(N-1), t2=(t1*m)>>(N+1) and r=p-t2*q, keeping the low W+2 bits.
  - S4 subtracts q from r up to twice while r>=q, then applies the post-operation.
- Modular add: sum is reduced by one conditional subtract of q.
- Modular sub: a negative difference has q added back.
- Halving: v/2 mod q = v>>1 if v is even, else (v+q)>>1, computed W+1 bits wide.
- Operations:
  - 0 ADD: out0=(a+b) mod q, out1=0.
  - 1 SUB: out0=(a-b) mod q, out1=0.
  - 2 MUL: out0=a*b mod q, out1=0.
  - 3 CT: t=b*w mod q, out0=(a+t) mod q, out1=(a-t) mod q.
  - 4 GS: out0=(a+b) mod q, out1=((a-b)*w) mod q.
  - 5 GSH: out0=((a+b)/2) mod q, out1=(((a-b)*w)/2) mod q.
  - 6 and 7 PASS: out0=a, out1=b, with the same latency.
- Out-of-range operands (>=q): results are unspecified, but the pipeline must not hang or corrupt neighbouring beats.
- poly_flush: clears all valid bits on the next edge and has priority over stall. A beat presented in the same cycle is discarded. Data registers need not clear.
- poly_busy is the OR of all stage valid bits, including the output stage.
- Reset asserted mid-operation: all in-flight beats are lost. poly_in_ready is 1 on the first cycle after reset deassertion.

Test Plan:
All cases use q=8380417, N=23, m=8396807.
- ADD a=8380416, b=2 -> out0=1, out1=0, with out_valid exactly 4 cycles after acceptance (EXTRA_PIPE=0).
- SUB a=0, b=1 -> out0=8380416. MUL a=b=8380416 -> out0=1. MUL a=4190209, b=2 -> out0=1.
- CT a=5, b=8380416, w=8380416 -> out0=6, out1=4. GS a=3, b=1, w=2 -> out0=4, out1=4.
- GSH a=1, b=0, w=1 -> out0=4190209, out1=4190209. GSH a=4, b=2, w=1 -> out0=3, out1=1.
- Back-pressure: stream 16 random ops back-to-back with poly_out_ready toggling pseudo-randomly. Required:
  - every result matches the software model, in order;
  - none dropped or duplicated;
  - outputs are stable while stalled;
  - poly_in_ready is low exactly when out_valid && !out_ready.
- Flush and reset: issue 3 beats, then pulse poly_flush -> no out_valid and poly_busy=0 on the next cycle. Repeat with poly_rst asserted mid-stream -> all outputs 0 immediately, and a fresh beat after release completes correctly.

Source files
------------

// File: rtl/poly_alu_pipe.sv
// Fully pipelined modular polynomial ALU: add/sub/mul, CT/GS butterflies and GS with halving,
// Barrett reduction against a runtime modulus, with valid/ready back-pressure (global stall).
module poly_alu_pipe #(
  parameter int W          = 24,
  parameter int EXTRA_PIPE = 0
) (
  input  logic         poly_clk,
  input  logic         poly_rst,
  input  logic         poly_flush,
  input  logic [2:0]   poly_op,
  input  logic         poly_in_valid,
  output logic         poly_in_ready,
  input  logic [W-1:0] poly_a,
  input  logic [W-1:0] poly_b,
  input  logic [W-1:0] poly_w,
  input  logic [W-1:0] poly_q,
  input  logic [4:0]   poly_q_width,
  input  logic [W:0]   poly_barret_m,
  output logic         poly_out_valid,
  input  logic         poly_out_ready,
  output logic [W-1:0] poly_out0,
  output logic [W-1:0] poly_out1,
  output logic         poly_busy
);

  localparam int OS = EXTRA_PIPE + 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_CT  = 3'd3;
  localparam logic [2:0] OP_GS  = 3'd4;
  localparam logic [2:0] OP_GSH = 3'd5;

  function automatic logic [W-1:0] mod_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [W-1:0] q);
    logic [W:0] sum;
    sum = {1'b0, x} + {1'b0, y};
    if (sum >= {1'b0, q}) sum = sum - {1'b0, q};
    else                  sum = sum;
    return sum[W-1:0];
  endfunction

  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [W-1:0] q);
    logic [W:0] diff;
    diff = {1'b0, x} - {1'b0, y};
    if (x < y) diff = diff + {1'b0, q};
    else       diff = diff;
    return diff[W-1:0];
  endfunction

  // Odd values borrow q so the shift stays exact; sum needs W+1 bits.
  function automatic logic [W-1:0] mod_half(input logic [W-1:0] v, input logic [W-1:0] q);
    logic [W:0] t;
    if (v[0]) t = {1'b0, v} + {1'b0, q};
    else      t = {1'b0, v};
    return t[W:1];
  endfunction

  logic stall_s;
  assign stall_s       = poly_out_valid & ~poly_out_ready;
  assign poly_in_ready = ~stall_s;

  logic           s1_vld_q, s2_vld_q, s3_vld_q, s4_vld_q;
  logic [2:0]     s1_op_q, s2_op_q, s3_op_q, s4_op_q;
  logic [W-1:0]   s1_a_q, s1_b_q, s1_w_q;
  logic [W-1:0]   s2_a_q, s2_b_q, s2_s_q, s2_d_q;
  logic [W-1:0]   s3_a_q, s3_b_q, s3_s_q, s3_d_q;
  logic [W-1:0]   s4_a_q, s4_b_q, s4_s_q, s4_d_q, s4_t_q;
  logic [2*W-1:0] s2_p_q;
  logic [W+1:0]   s3_r_q;

  logic [W-1:0]   s1_s_d, s1_d_d, s1_x_d, s1_y_d;
  logic [2*W-1:0] s1_p_d;

  // Stage 1 pre-sum/pre-difference and multiplier operand selection.
  always_comb begin
    s1_s_d = mod_add(s1_a_q, s1_b_q, poly_q);
    s1_d_d = mod_sub(s1_a_q, s1_b_q, poly_q);
    s1_x_d = s1_a_q;
    s1_y_d = s1_b_q;
    case (s1_op_q)
      OP_CT: begin
        s1_x_d = s1_b_q;
        s1_y_d = s1_w_q;
      end
      OP_GS, OP_GSH: begin
        s1_x_d = s1_d_d;
        s1_y_d = s1_w_q;
      end
      default: begin
        s1_x_d = s1_a_q;
        s1_y_d = s1_b_q;
      end
    endcase
    s1_p_d = {{W{1'b0}}, s1_x_d} * {{W{1'b0}}, s1_y_d};
  end

  logic [5:0]     sh_lo_s, sh_hi_s;
  logic [2*W-1:0] s2_pshift_s;
  logic [W:0]     s2_t1_s, s2_t2_s;
  logic [2*W+1:0] s2_t1m_s, s2_t1m_sh_s;
  logic [W+1:0]   s2_t2q_s, s2_r_d;

  assign sh_lo_s = {1'b0, poly_q_width} - 6'd1;
  assign sh_hi_s = {1'b0, poly_q_width} + 6'd1;

  // Barrett estimate of floor(p/q); the remainder lands in [0,3q).
  always_comb begin
    s2_pshift_s = s2_p_q >> sh_lo_s;
    s2_t1_s     = s2_pshift_s[W:0];
    s2_t1m_s    = {{(W+1){1'b0}}, s2_t1_s} * {{(W+1){1'b0}}, poly_barret_m};
    s2_t1m_sh_s = s2_t1m_s >> sh_hi_s;
    s2_t2_s     = s2_t1m_sh_s[W:0];
    s2_t2q_s    = {1'b0, s2_t2_s} * {2'b00, poly_q};
    s2_r_d      = s2_p_q[W+1:0] - s2_t2q_s;
  end

  logic [W+1:0] qx_s, s3_r1_s, s3_r2_s;

  // Final correction of the Barrett remainder.
  always_comb begin
    qx_s = {2'b00, poly_q};
    if (s3_r_q >= qx_s) s3_r1_s = s3_r_q - qx_s;
    else                s3_r1_s = s3_r_q;
    if (s3_r1_s >= qx_s) s3_r2_s = s3_r1_s - qx_s;
    else                 s3_r2_s = s3_r1_s;
  end

  logic [W-1:0] o0_d, o1_d;

  // Post-operation per opcode.
  always_comb begin
    o0_d = '0;
    o1_d = '0;
    case (s4_op_q)
      OP_ADD: o0_d = s4_s_q;
      OP_SUB: o0_d = s4_d_q;
      OP_MUL: o0_d = s4_t_q;
      OP_CT: begin
        o0_d = mod_add(s4_a_q, s4_t_q, poly_q);
        o1_d = mod_sub(s4_a_q, s4_t_q, poly_q);
      end
      OP_GS: begin
        o0_d = s4_s_q;
        o1_d = s4_t_q;
      end
      OP_GSH: begin
        o0_d = mod_half(s4_s_q, poly_q);
        o1_d = mod_half(s4_t_q, poly_q);
      end
      default: begin
        o0_d = s4_a_q;
        o1_d = s4_b_q;
      end
    endcase
  end

  logic unused_bits_s;
  assign unused_bits_s = ^{s2_pshift_s[2*W-1:W+1], s2_t1m_sh_s[2*W+1:W+1], s3_r2_s[W+1:W]};

  logic [OS-1:0] ov_q;
  logic [W-1:0]  o0_q [OS];
  logic [W-1:0]  o1_q [OS];

  // Stage valid bits; flush wins over stall.
  always_ff @(posedge poly_clk or posedge poly_rst) begin
    if (poly_rst) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s3_vld_q <= 1'b0;
      s4_vld_q <= 1'b0;
      ov_q     <= '0;
    end else if (poly_flush) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s3_vld_q <= 1'b0;
      s4_vld_q <= 1'b0;
      ov_q     <= '0;
    end else if (!stall_s) begin
      s1_vld_q <= poly_in_valid;
      s2_vld_q <= s1_vld_q;
      s3_vld_q <= s2_vld_q;
      s4_vld_q <= s3_vld_q;
      ov_q[0]  <= s4_vld_q;
      for (int i = 1; i < OS; i++) ov_q[i] <= ov_q[i-1];
    end
  end

  // Stage data registers, all advancing together unless stalled.
  always_ff @(posedge poly_clk or posedge poly_rst) begin
    if (poly_rst) begin
      s1_op_q <= 3'd0; s1_a_q <= '0; s1_b_q <= '0; s1_w_q <= '0;
      s2_op_q <= 3'd0; s2_a_q <= '0; s2_b_q <= '0; s2_s_q <= '0; s2_d_q <= '0; s2_p_q <= '0;
      s3_op_q <= 3'd0; s3_a_q <= '0; s3_b_q <= '0; s3_s_q <= '0; s3_d_q <= '0; s3_r_q <= '0;
      s4_op_q <= 3'd0; s4_a_q <= '0; s4_b_q <= '0; s4_s_q <= '0; s4_d_q <= '0; s4_t_q <= '0;
    end else if (!stall_s) begin
      s1_op_q <= poly_op; s1_a_q <= poly_a; s1_b_q <= poly_b; s1_w_q <= poly_w;
      s2_op_q <= s1_op_q; s2_a_q <= s1_a_q; s2_b_q <= s1_b_q;
      s2_s_q  <= s1_s_d;  s2_d_q <= s1_d_d; s2_p_q <= s1_p_d;
      s3_op_q <= s2_op_q; s3_a_q <= s2_a_q; s3_b_q <= s2_b_q;
      s3_s_q  <= s2_s_q;  s3_d_q <= s2_d_q; s3_r_q <= s2_r_d;
      s4_op_q <= s3_op_q; s4_a_q <= s3_a_q; s4_b_q <= s3_b_q;
      s4_s_q  <= s3_s_q;  s4_d_q <= s3_d_q; s4_t_q <= s3_r2_s[W-1:0];
    end
  end

  // Output register chain.
  always_ff @(posedge poly_clk or posedge poly_rst) begin
    if (poly_rst) begin
      for (int i = 0; i < OS; i++) begin
        o0_q[i] <= '0;
        o1_q[i] <= '0;
      end
    end else if (!stall_s) begin
      o0_q[0] <= o0_d;
      o1_q[0] <= o1_d;
      for (int i = 1; i < OS; i++) begin
        o0_q[i] <= o0_q[i-1];
        o1_q[i] <= o1_q[i-1];
      end
    end
  end

  assign poly_out_valid = ov_q[OS-1];
  assign poly_out0      = o0_q[OS-1];
  assign poly_out1      = o1_q[OS-1];
  assign poly_busy      = s1_vld_q | s2_vld_q | s3_vld_q | s4_vld_q | (|ov_q);

endmodule

// File: tb/tb_poly_alu_pipe.sv
// Scoreboard bench for poly_alu_pipe: directed and random beats checked against
// a plain modular-arithmetic reference model, with back-pressure, flush and reset.
module tb_poly_alu_pipe;
  localparam int          W = 24;
  localparam logic [23:0] Q = 24'd8380417;

  logic        clk = 1'b0;
  logic        poly_rst, poly_flush, poly_in_valid, poly_in_ready;
  logic [2:0]  poly_op;
  logic [23:0] poly_a, poly_b, poly_w, poly_q, poly_out0, poly_out1;
  logic [4:0]  poly_q_width;
  logic [24:0] poly_barret_m;
  logic        poly_out_valid, poly_out_ready, poly_busy;

  always #5 clk = ~clk;

  poly_alu_pipe #(.W(W), .EXTRA_PIPE(0)) dut (
    .poly_clk(clk), .poly_rst(poly_rst), .poly_flush(poly_flush), .poly_op(poly_op),
    .poly_in_valid(poly_in_valid), .poly_in_ready(poly_in_ready),
    .poly_a(poly_a), .poly_b(poly_b), .poly_w(poly_w), .poly_q(poly_q),
    .poly_q_width(poly_q_width), .poly_barret_m(poly_barret_m),
    .poly_out_valid(poly_out_valid), .poly_out_ready(poly_out_ready),
    .poly_out0(poly_out0), .poly_out1(poly_out1), .poly_busy(poly_busy)
  );

  int          n_total = 0;
  int          n_pass  = 0;
  logic [47:0] sb[$];
  bit          rand_rdy = 1'b0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Reference: direct modular arithmetic; halving is multiplication by the inverse of 2.
  function automatic logic [47:0] model(input logic [2:0] op, input logic [23:0] a,
                                        input logic [23:0] b, input logic [23:0] w);
    longint q, inv2, la, lb, lw, t, r0, r1;
    q = 64'd8380417; inv2 = (q + 1) / 2;
    la = a; lb = b; lw = w; r0 = 0; r1 = 0;
    case (op)
      3'd0: r0 = (la + lb) % q;
      3'd1: r0 = (la - lb + q) % q;
      3'd2: r0 = (la * lb) % q;
      3'd3: begin t = (lb * lw) % q; r0 = (la + t) % q; r1 = (la - t + q) % q; end
      3'd4: begin r0 = (la + lb) % q; r1 = (((la - lb + q) % q) * lw) % q; end
      3'd5: begin
        r0 = (((la + lb) % q) * inv2) % q;
        r1 = (((((la - lb + q) % q) * lw) % q) * inv2) % q;
      end
      default: begin r0 = la; r1 = lb; end
    endcase
    return {r0[23:0], r1[23:0]};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
    if (rand_rdy) poly_out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [2:0] op, input logic [23:0] a, input logic [23:0] b,
                      input logic [23:0] w, input logic [47:0] exp);
    int guard;
    guard = 0;
    poly_op = op; poly_a = a; poly_b = b; poly_w = w; poly_in_valid = 1'b1;
    @(negedge clk);
    while (!poly_in_ready && guard < 200) begin
      tick();
      @(negedge clk);
      guard++;
    end
    if (!poly_in_ready) begin
      n_total++;
      $display("FAIL send_timeout: in_ready stuck at %0b, required 1", poly_in_ready);
    end else begin
      sb.push_back(exp);
    end
    tick();
    poly_in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && sb.size() != 0; i++) tick();
    check("drain_empty", 48'(sb.size()), 48'd0);
  endtask

  logic [23:0] h0, h1;
  bit          hold = 1'b0;

  // Monitor: handshake rule, stall stability and in-order scoreboard compare.
  always @(negedge clk) begin
    logic [47:0] e;
    if (poly_rst) begin
      hold = 1'b0;
    end else begin
      check("in_ready_rule", 48'(poly_in_ready), 48'(!(poly_out_valid && !poly_out_ready)));
      if (hold) begin
        check("stall_valid", 48'(poly_out_valid), 48'd1);
        check("stall_stable", {poly_out0, poly_out1}, {h0, h1});
      end
      if (poly_out_valid && poly_out_ready) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_result: got out0=%0d out1=%0d, required no result",
                   poly_out0, poly_out1);
        end else begin
          e = sb.pop_front();
          check("result", {poly_out0, poly_out1}, e);
        end
      end
      hold = poly_out_valid && !poly_out_ready;
      h0   = poly_out0;
      h1   = poly_out1;
    end
  end

  logic [2:0]  d_op [8] = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6};
  logic [23:0] d_a  [8] = '{24'd0, 24'd8380416, 24'd4190209, 24'd5, 24'd3, 24'd1, 24'd4, 24'd77};
  logic [23:0] d_b  [8] = '{24'd1, 24'd8380416, 24'd2, 24'd8380416, 24'd1, 24'd0, 24'd2, 24'd99};
  logic [23:0] d_w  [8] = '{24'd0, 24'd0, 24'd0, 24'd8380416, 24'd2, 24'd1, 24'd1, 24'd5};
  logic [47:0] d_e  [8] = '{{24'd8380416, 24'd0}, {24'd1, 24'd0}, {24'd1, 24'd0},
                           {24'd6, 24'd4}, {24'd4, 24'd4}, {24'd4190209, 24'd4190209},
                           {24'd3, 24'd1}, {24'd77, 24'd99}};

  initial begin
    logic [2:0]  op;
    logic [23:0] a, b, w;
    poly_rst = 1'b1; poly_flush = 1'b0; poly_in_valid = 1'b0; poly_op = 3'd0;
    poly_a = '0; poly_b = '0; poly_w = '0; poly_out_ready = 1'b1;
    poly_q = Q; poly_q_width = 5'd23; poly_barret_m = 25'd8396807;
    repeat (3) tick();
    check("rst_out_valid", 48'(poly_out_valid), 48'd0);
    check("rst_busy", 48'(poly_busy), 48'd0);
    check("rst_outs", {poly_out0, poly_out1}, 48'd0);
    poly_rst = 1'b0;
    check("in_ready_after_rst", 48'(poly_in_ready), 48'd1);

    send(3'd0, 24'd8380416, 24'd2, 24'd0, {24'd1, 24'd0});
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("latency_valid", 48'(poly_out_valid), 48'(i == 4));
    end
    drain();

    for (int i = 0; i < 8; i++) send(d_op[i], d_a[i], d_b[i], d_w[i], d_e[i]);
    drain();

    rand_rdy = 1'b1;
    for (int i = 0; i < 64; i++) begin
      op = 3'($urandom_range(0, 7));
      a = 24'($urandom_range(0, 8380416));
      b = 24'($urandom_range(0, 8380416));
      w = 24'($urandom_range(0, 8380416));
      send(op, a, b, w, model(op, a, b, w));
      if (i >= 16 && $urandom_range(0, 3) == 0) tick();
    end
    drain();
    rand_rdy = 1'b0;
    poly_out_ready = 1'b1;
    tick();

    for (int i = 0; i < 3; i++) send(3'd0, 24'(i), 24'd1, 24'd0, model(3'd0, 24'(i), 24'd1, 24'd0));
    poly_flush = 1'b1;
    poly_in_valid = 1'b1;
    tick();
    poly_flush = 1'b0;
    poly_in_valid = 1'b0;
    check("flush_out_valid", 48'(poly_out_valid), 48'd0);
    check("flush_busy", 48'(poly_busy), 48'd0);
    sb.delete();
    repeat (8) tick();
    check("post_flush_busy", 48'(poly_busy), 48'd0);

    poly_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(3'd0, 24'(10 + i), 24'd20, 24'd0, {24'(30 + i), 24'd0});
    repeat (2) tick();
    check("stalled_head", {poly_out0, poly_out1, poly_out_valid} >> 1, {24'd30, 24'd0});
    poly_rst = 1'b1;
    #1;
    check("midrst_out_valid", 48'(poly_out_valid), 48'd0);
    check("midrst_outs", {poly_out0, poly_out1}, 48'd0);
    check("midrst_busy", 48'(poly_busy), 48'd0);
    sb.delete();
    repeat (2) tick();
    poly_rst = 1'b0;
    poly_out_ready = 1'b1;
    check("in_ready_after_midrst", 48'(poly_in_ready), 48'd1);
    send(3'd2, 24'd4190209, 24'd2, 24'd0, {24'd1, 24'd0});
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
